serial_subtractor: RTL and testbench

Parametrised bit-serial N-bit subtractor built around a single full-subtractor cell and a borrow flip-flop. It computes d = a - b - bin, LSB first, one bit per clock, with a start/busy/done handshake. Completed results are held in output registers until the next result is ready. It is the sequential, multi-bit successor to the combinational half subtractor, for datapaths that trade latency for area.

---
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: d = a - b - bin, LSB first, one bit per
// clock through a single full-subtractor cell and a borrow flop. The finished
// result is captured into held output registers when the last bit completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand shift registers: bit 0 is always the bit being processed.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Working result; each new difference bit enters at the MSB.
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             br_nxt;
  logic             diff_bit;
  logic             a_msb;
  logic             b_msb;
  logic             accept;
  logic             last_bit;

  // Difference output of the full-subtractor cell.
  function automatic logic fs_diff(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  // Borrow output of the full-subtractor cell.
  function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  // Signed overflow: operands differ in sign and the result sign differs from a.
  function automatic logic sub_ovf(input logic am, input logic bm, input logic rm);
    return (am != bm) && (rm != am);
  endfunction

  // Handshake decode and the single subtractor cell.
  always_comb begin
    accept   = start && ((state == IDLE) || (state == DONE));
    last_bit = (state == SHIFT) && (cnt == LAST_IDX);
    diff_bit = fs_diff(a_sh[0], b_sh[0], br);
    br_nxt   = fs_borrow(a_sh[0], b_sh[0], br);
    res_nxt  = {diff_bit, res_sh[WIDTH-1:1]};
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE may chain straight into SHIFT on a new start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state, so they never overlap.
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Operand capture, bit-serial processing and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      d      <= '0;
      bo     <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      br     <= bin;
      cnt    <= '0;
      res_sh <= '0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      br     <= br_nxt;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        d   <= res_nxt;
        bo  <= br_nxt;
        ovf <= sub_ovf(a_msb, b_msb, res_nxt[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance for directed
// vectors and a 2-bit instance for an exhaustive sweep against a model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bo8, ovf8;
  logic [7:0] d8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       bin2 = 1'b0;
  logic       busy2, done2, bo2, ovf2;
  logic [1:0] d2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] exp8_q[$];   // {d, bo, ovf}
  logic [3:0] exp2_q[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .bo(bo8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .d(d2), .bo(bo2), .ovf(ovf2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop expected result whenever a done pulse is presented.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (exp8_q.size() == 0) chk("dut8 unexpected done", 32'd1, 32'd0);
      else chk("dut8 result {d,bo,ovf}", {22'd0, d8, bo8, ovf8}, {22'd0, exp8_q.pop_front()});
    end
    if (!rst && done2) begin
      if (exp2_q.size() == 0) chk("dut2 unexpected done", 32'd1, 32'd0);
      else chk("dut2 result {d,bo,ovf}", {28'd0, d2, bo2, ovf2}, {28'd0, exp2_q.pop_front()});
    end
    if (!rst && ((busy8 && done8) || (busy2 && done2)))
      chk("busy and done together", 32'd1, 32'd0);
  end

  task automatic wait_done8();
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin seen = 1; break; end
    end
    if (!seen) chk("dut8 done timeout", 32'd0, 32'd1);
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic ebo, input logic eovf);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    exp8_q.push_back({ed, ebo, eovf});
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
  endtask

  task automatic go2(input logic [1:0] a, input logic [1:0] b, input logic bi);
    int diff, sa, sb, sr;
    logic [1:0] ed;
    bit seen = 0;
    diff = int'(a) - int'(b) - int'(bi);
    ed   = 2'(diff & 3);
    sa   = (a >= 2) ? int'(a) - 4 : int'(a);
    sb   = (b >= 2) ? int'(b) - 4 : int'(b);
    sr   = sa - sb - int'(bi);
    @(negedge clk);
    a2 = a; b2 = b; bin2 = bi; start2 = 1'b1;
    exp2_q.push_back({ed, (diff < 0), (sr < -2 || sr > 1)});
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done2) begin seen = 1; break; end
    end
    if (!seen) chk("dut2 done timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_at;
    bit done_seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset busy", busy8, 0);
    chk("reset done", done8, 0);
    chk("reset d/bo/ovf", {d8, bo8, ovf8}, 0);
    rst = 1'b0;

    // 1: 0x05 - 0x03, with latency profile
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    exp8_q.push_back({8'h02, 1'b0, 1'b0});
    busy_cnt = 0; done_at = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
      if (busy8) busy_cnt++;
      if (done8 && done_at == 0) done_at = k;
    end
    chk("busy cycle count", busy_cnt, 8);
    chk("done latency", done_at, 9);

    // 4: hold of previous result, ignored mid-SHIFT start, back-to-back start
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    exp8_q.push_back({8'h0F, 1'b0, 1'b0});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (k == 3) begin a8 = 8'hAA; b8 = 8'h00; start8 = 1'b1; end
      chk("d held during SHIFT", {busy8, d8}, {1'b1, 8'h02});
    end
    @(negedge clk);
    chk("done after 8 bits", done8, 1);
    a8 = 8'h20; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    exp8_q.push_back({8'h1F, 1'b0, 1'b0});
    @(negedge clk);
    start8 = 1'b0;
    chk("back-to-back busy", {busy8, done8}, 2'b10);
    wait_done8();

    // 2 and 3: borrow and overflow vectors
    go8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    go8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    go8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    go8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // 5: asynchronous reset in cycle 4 of SHIFT aborts the operation
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("async reset clears busy/d/bo/ovf", {busy8, d8, bo8, ovf8}, 0);
    #1;
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) done_seen = 1;
    end
    chk("no done after abort", done_seen, 0);
    go8(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    // 6: exhaustive 2-bit sweep
    for (int ai = 0; ai < 4; ai++)
      for (int bi = 0; bi < 4; bi++)
        for (int ci = 0; ci < 2; ci++)
          go2(2'(ai), 2'(bi), 1'(ci));

    repeat (3) @(negedge clk);
    chk("dut8 scoreboard drained", exp8_q.size(), 0);
    chk("dut2 scoreboard drained", exp2_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
